mem_port_arbiter: RTL and testbench

Arbiter that shares one single-ported, variable-latency unified memory between the instruction-fetch (IF) and data-memory (MEM) stages of the pipelined MIPS core. It sits between the two stage ports and the memory in `top`. It grants one transaction at a time and returns read data and a one-cycle done pulse to the granted port. It also drives the stall signals that freeze the pipeline while a stage's access is outstanding.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch (IF) and data-memory (MEM) pipeline stages.
//
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   i_req/i_addr            IF read request (held until i_done)
//   i_rdata/i_done          IF read data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  MEM request (held until d_done)
//   d_rdata/d_done          MEM load data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request side
//   mem_rdata/mem_ack       memory response (data valid with ack)
//   stall_if/stall_mem      combinational stall outputs to the pipeline
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            i_done_q, i_done_d;
  logic            d_done_q, d_done_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;

  logic ei_c, ed_c, grant_d_c, grant_i_c;

  // Effective requests: a port is masked in the cycle its done pulse is out
  assign ei_c = i_req & ~i_done_q;
  assign ed_c = d_req & ~d_done_q;

  // Data wins unless it has used up its streak while IF is waiting
  assign grant_d_c = (state_q == IDLE) & ed_c & ((streak_q < STREAK_MAX) | ~ei_c);
  assign grant_i_c = (state_q == IDLE) & ~grant_d_c & ei_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          state_d = DBUSY;
        end else if (grant_i_c) begin
          state_d = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    streak_d    = streak_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    mem_req_d   = (state_d != IDLE);
    // Latched store flag survives only while the data transaction is open
    mem_we_d    = (state_d == DBUSY) ? mem_we_q : 1'b0;

    if (grant_d_c) begin
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_we_d    = d_we;
      if (ei_c) begin
        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + SW'(1);
      end else begin
        streak_d = SW'(1);
      end
    end

    if (grant_i_c) begin
      mem_addr_d = i_addr;
      mem_we_d   = 1'b0;
      streak_d   = '0;
    end

    if (mem_ack && (state_q == IBUSY)) begin
      i_rdata_d = mem_rdata;
      i_done_d  = 1'b1;
    end

    if (mem_ack && (state_q == DBUSY)) begin
      d_rdata_d = mem_rdata;
      d_done_d  = 1'b1;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall_if  = i_req & ~i_done_q;
  assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          MAXS = 4;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall_if;
  logic          stall_mem;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the memory (0 none, 1 IF, 2 data) plus what was latched
  int          m_owner;
  int          m_streak;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic        m_we, m_idone, m_ddone;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic model_step();
    bit ei, ed, nid, ndd;
    if (!reset) begin
      m_owner = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_we = 0;
      m_idone = 0; m_ddone = 0; m_irdata = '0; m_drdata = '0;
    end else begin
      ei = i_req && !m_idone;
      ed = d_req && !m_ddone;
      nid = 0; ndd = 0;
      if (m_owner == 0) begin
        if (ed && (m_streak < MAXS || !ei)) begin
          m_owner = 2; m_addr = d_addr; m_wdata = d_wdata; m_we = d_we;
          m_streak = ei ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 1;
        end else if (ei) begin
          m_owner = 1; m_addr = i_addr; m_we = 0; m_streak = 0;
        end
      end else if (mem_ack) begin
        if (m_owner == 1) begin m_irdata = mem_rdata; nid = 1; end
        else begin m_drdata = mem_rdata; ndd = 1; end
        m_owner = 0;
      end
      m_idone = nid;
      m_ddone = ndd;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0; i_req = 1; i_addr = 32'h0000_1234;
    tick(); tick();
    n_tests++;
    if ({mem_req, mem_we, i_done, d_done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, i_done, d_done});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    reset = 1;
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1234 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got req=%b addr=%h we=%b want req=1 addr=00001234 we=0", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    n_tests++;
    if (i_done !== 1'b1 || i_rdata !== 32'hCAFE_0001 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL reset_ifetch_done: got done=%b rdata=%h stall=%b want 1 cafe0001 0", i_done, i_rdata, stall_if);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single_load();
    do_reset(); idle_inputs();
    d_req = 1; d_we = 0; d_addr = 32'h50; #1;
    n_tests++;
    if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0: got %b want 1", stall_mem); end
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h50 || mem_we !== 1'b0 || stall_mem !== 1'b1) begin
      n_fail++; $display("FAIL load_c1: got req=%b addr=%h we=%b stall=%b want 1 50 0 1", mem_req, mem_addr, mem_we, stall_mem);
    end
    mem_ack = 1; mem_rdata = 32'd7;
    tick();
    n_tests++;
    if (d_done !== 1'b1 || d_rdata !== 32'd7 || stall_mem !== 1'b0 || i_done !== 1'b0) begin
      n_fail++; $display("FAIL load_done: got done=%b rdata=%h stall=%b idone=%b want 1 7 0 0", d_done, d_rdata, stall_mem, i_done);
    end
    d_req = 0; mem_ack = 0;
    tick();
    n_tests++;
    if (d_done !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL load_pulse_width: got done=%b req=%b want 0 0", d_done, mem_req);
    end
  endtask

  task automatic test_store_wait();
    do_reset(); idle_inputs();
    d_req = 1; d_we = 1; d_addr = 32'd80; d_wdata = 32'd7;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd80 || mem_wdata !== 32'd7 || d_done !== 1'b0) begin
        n_fail++; $display("FAIL store_hold%0d: got req=%b we=%b addr=%0d wdata=%0d done=%b want 1 1 80 7 0", k, mem_req, mem_we, mem_addr, mem_wdata, d_done);
      end
      // Requester-side changes while granted must not disturb the latched request
      d_addr = 32'hFFFF; d_wdata = 32'hEEEE;
      if (k == 3) mem_ack = 1;
      tick();
    end
    n_tests++;
    if (d_done !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL store_done: got done=%b req=%b we=%b want 1 0 0", d_done, mem_req, mem_we);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset(); idle_inputs();
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h800;
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h800) begin
      n_fail++; $display("FAIL simul_first: got req=%b addr=%h want 1 800", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h11;
    tick();
    n_tests++;
    if (d_done !== 1'b1 || i_done !== 1'b0 || d_rdata !== 32'h11) begin
      n_fail++; $display("FAIL simul_ddone: got d=%b i=%b rdata=%h want 1 0 11", d_done, i_done, d_rdata);
    end
    d_req = 0; mem_ack = 0;
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL simul_if_grant: got req=%b addr=%h we=%b want 1 400 0", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1; mem_rdata = 32'h22;
    tick();
    n_tests++;
    if (i_done !== 1'b1 || d_done !== 1'b0 || i_rdata !== 32'h22) begin
      n_fail++; $display("FAIL simul_idone: got i=%b d=%b rdata=%h want 1 0 22", i_done, d_done, i_rdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    int drun, dmax, igr, dgr;
    do_reset(); idle_inputs();
    drun = 0; dmax = 0; igr = 0; dgr = 0;
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; mem_ack = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_req) begin
        if (mem_addr == 32'h200) begin drun++; dgr++; if (drun > dmax) dmax = drun; end
        else if (mem_addr == 32'h100) begin igr++; drun = 0; end
      end
    end
    n_tests++;
    if (dmax > MAXS || dmax < 1) begin
      n_fail++; $display("FAIL starve_streak: got max data run %0d want 1..%0d", dmax, MAXS);
    end
    n_tests++;
    if (igr < 40 / (2 * (MAXS + 1)) || dgr < 1) begin
      n_fail++; $display("FAIL starve_if_grants: got if=%0d data=%0d want if>=%0d data>=1", igr, dgr, 40 / (2 * (MAXS + 1)));
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    do_reset(); idle_inputs();
    d_req = 1; d_we = 0; d_addr = 32'h60;
    tick(); tick();
    reset = 0;
    tick();
    n_tests++;
    if (mem_req !== 1'b0 || d_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset: got req=%b done=%b want 0 0", mem_req, d_done);
    end
    reset = 1; d_req = 0; mem_ack = 1; mem_rdata = 32'h99;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (mem_req !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0) begin
        n_fail++; $display("FAIL abort_stray_ack%0d: got req=%b d=%b i=%b want 0 0 0", c, mem_req, d_done, i_done);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    reset = 0;
    for (int c = 0; c < 2; c++) begin @(posedge clk); model_step(); #1; end
    reset = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      n_tests++;
      if (mem_req !== (m_owner != 0) || mem_we !== (m_owner == 2 && m_we) ||
          i_done !== m_idone || d_done !== m_ddone) begin
        n_fail++; $display("FAIL rand_ctrl@%0d: got req=%b we=%b id=%b dd=%b want %b %b %b %b", c,
                           mem_req, mem_we, i_done, d_done, m_owner != 0, m_owner == 2 && m_we, m_idone, m_ddone);
      end
      if (m_owner != 0) begin
        n_tests++;
        if (mem_addr !== m_addr) begin n_fail++; $display("FAIL rand_addr@%0d: got %h want %h", c, mem_addr, m_addr); end
      end
      if (m_owner == 2 && m_we) begin
        n_tests++;
        if (mem_wdata !== m_wdata) begin n_fail++; $display("FAIL rand_wdata@%0d: got %h want %h", c, mem_wdata, m_wdata); end
      end
      if (m_idone) begin
        n_tests++;
        if (i_rdata !== m_irdata) begin n_fail++; $display("FAIL rand_irdata@%0d: got %h want %h", c, i_rdata, m_irdata); end
      end
      if (m_ddone && !m_we) begin
        n_tests++;
        if (d_rdata !== m_drdata) begin n_fail++; $display("FAIL rand_drdata@%0d: got %h want %h", c, d_rdata, m_drdata); end
      end
      // Requesters hold until done, then may drop or reissue
      if (m_idone || !i_req) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = $urandom();
      end
      if (m_ddone || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        d_addr = $urandom(); d_wdata = $urandom(); d_we = $urandom_range(0, 1) != 0;
      end
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom();
      reset     = ($urandom_range(0, 199) != 0);
      #1;
      n_tests++;
      if (stall_if !== (i_req && !m_idone) || stall_mem !== (d_req && !m_ddone)) begin
        n_fail++; $display("FAIL rand_stall@%0d: got if=%b mem=%b want %b %b", c, stall_if, stall_mem,
                           i_req && !m_idone, d_req && !m_ddone);
      end
    end
    idle_inputs();
    reset = 1;
    tick();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_single_load();
    test_store_wait();
    test_simultaneous();
    test_starvation();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
